mult_unit: RTL and testbench
============================

MULT_UNIT -- requirements
Module: mult_unit

Interface
REQ-001 The block SHALL have clock clk and reset reset; reset is asynchronous and active-high.
REQ-002 clk  input  1  rising-edge clock.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 start  input  1  execute-stage multiply request (startMultE), sampled on the rising edge.
REQ-005 signed_mode  input  1  1 = mult (two's complement), 0 = multu (signedMultE).
REQ-006 a, b  input  32 each  operands (forwarded rs and rt values).
REQ-007 mf_sel  input  2  2'b00 none, 2'b01 mfhi, 2'b10 mflo, 2'b11 reserved (mfRegE).
REQ-008 mf_out  output  32  HI or LO value selected by mf_sel.
REQ-009 busy  output  1  high while a multiply is in progress.
REQ-010 done  output  1  one-cycle pulse when HI/LO are updated.
REQ-011 stall  output  1  request to the hazard unit to freeze the F/D/E stages.

Function
REQ-012 The state machine SHALL have three states: IDLE, BUSY and FIX.
REQ-013 IDLE with start=1 at an edge: capture |a| and |b| (or raw a and b when signed_mode=0), plus neg = signed_mode & (a[31]^b[31]); clear the 64-bit accumulator and the 6-bit count; go to BUSY.
REQ-014 BUSY: each cycle, if the multiplier LSB is 1, add the shifted multiplicand to the accumulator; shift the multiplicand left by 1 and the multiplier right by 1; increment count. Transition to FIX after the 32nd iteration.
REQ-015 The magnitude of 0x80000000 SHALL be 0x80000000, treated as unsigned; the product SHALL be correct for all 2^64 operand pairs in both modes.
REQ-016 FIX: {HI,LO} <= neg ? (~acc + 1) : acc, computed as a 64-bit wrap-around; done=1 for this cycle only; next state IDLE.
REQ-017 Latency (macro undefined): HI/LO SHALL be visible exactly 34 clock edges after the start edge (1 capture, 32 BUSY, 1 FIX).
REQ-018 busy SHALL be 1 in BUSY and FIX, and 0 in IDLE.
REQ-019 start asserted while busy=1 SHALL be ignored: no restart and no operand recapture.
REQ-020 start asserted in the same cycle that FIX completes SHALL be ignored; it is accepted only from IDLE.
REQ-021 HI and LO SHALL hold their values until the next FIX or reset, and SHALL remain unchanged through BUSY.
REQ-022 mf_out SHALL be combinational: HI when mf_sel=01, LO when mf_sel=10, otherwise 0.
REQ-023 stall = busy & (mf_sel != 00) | busy & start.
REQ-024 mf_sel reads in IDLE SHALL return the previous HI/LO with stall=0.

Reset
REQ-025 On reset assertion, the block SHALL immediately go to IDLE and clear HI, LO, the accumulator, the operands, count and neg to 0; busy, done and stall SHALL be 0.
REQ-026 Reset mid-operation SHALL abort the multiply; HI/LO SHALL read 0 afterwards and no done pulse SHALL be produced.
REQ-027 The first start after reset deassertion SHALL be accepted at the next rising edge.

Configuration
REQ-028 Macro MULT_EARLY_TERM_EN: when defined, BUSY SHALL transition to FIX on the first edge at which the remaining shifted multiplier equals 0, so latency = 2 + (index of the highest set bit of the magnitude of b) + 1 cycles, and b=0 gives 2 cycles. When the macro is undefined, latency is fixed at 34 cycles. Results SHALL be identical in both builds.

Verification
REQ-029 Unsigned: a=3, b=5, start for one cycle -> after 34 edges HI=0x00000000, LO=0x0000000F, a single done pulse, busy high for cycles 1-33.
REQ-030 Signed: a=0xFFFFFFFF, b=2 -> HI=0xFFFFFFFF, LO=0xFFFFFFFE. Signed a=b=0x80000000 -> HI=0x40000000, LO=0. Unsigned a=b=0xFFFFFFFF -> HI=0xFFFFFFFE, LO=0x00000001.
REQ-031 mf_sel=01 held from cycle 5 of a multiply -> stall=1 until FIX completes, then mf_out equals the new HI with stall=0.
REQ-032 Reset at cycle 10 of a multiply of 7*9 -> immediate IDLE, HI=LO=0, no done; a subsequent 7*9 -> LO=63.
REQ-033 start re-pulsed at cycle 12 with a=1, b=1 during a multiply of 6*7 -> ignored; LO=42 at cycle 34.
REQ-034 With MULT_EARLY_TERM_EN: 3*5 -> done in FIX at edge 5 (capture + 3 BUSY + FIX) with LO=15; b=0 -> done at edge 2 with HI=LO=0.

Source files
------------

// File: rtl/mult_if.sv
// Multiplier request/readback bus between the execute stage and mult_unit.
// The master drives the multiply request and the HI/LO read select.
// The slave returns the read data and the status/stall flags.
interface mult_if;
  logic        start;
  logic        signed_mode;
  logic [31:0] a;
  logic [31:0] b;
  logic [1:0]  mf_sel;
  logic [31:0] mf_out;
  logic        busy;
  logic        done;
  logic        stall;

  modport master (
    output start, signed_mode, a, b, mf_sel,
    input  mf_out, busy, done, stall
  );

  modport slave (
    input  start, signed_mode, a, b, mf_sel,
    output mf_out, busy, done, stall
  );
endinterface

// File: rtl/mult_unit.sv
// Sequential 32x32 shift-add multiplier with HI/LO result registers (mult/multu).
// Operands are reduced to magnitudes on capture, multiplied unsigned, and the
// sign is applied in a final FIX cycle.
// Optional build macro MULT_EARLY_TERM_EN: leave BUSY as soon as the remaining
// multiplier bits are all zero. The result is the same, only the latency changes.
//
//   state | meaning
//   IDLE  | waiting for start; HI/LO readable, no stall
//   BUSY  | one shift-add iteration per cycle
//   FIX   | apply sign, write HI/LO, pulse done
module mult_unit (
  input  logic    clk,
  input  logic    reset,
  mult_if.slave   bus
);

  typedef enum logic [1:0] {IDLE, BUSY, FIX} state_t;

  state_t      state_q, state_d;
  logic [63:0] acc_q, acc_d;
  logic [63:0] mcand_q, mcand_d;
  logic [31:0] mplier_q, mplier_d;
  logic [5:0]  count_q, count_d;
  logic        neg_q, neg_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;

  logic [31:0] mag_a, mag_b;
  logic [63:0] result;

  // Operand magnitudes; 0x80000000 negates to itself and is used as unsigned.
  always_comb begin
    mag_a = (bus.signed_mode && bus.a[31]) ? (~bus.a + 32'd1) : bus.a;
    mag_b = (bus.signed_mode && bus.b[31]) ? (~bus.b + 32'd1) : bus.b;
    result = neg_q ? (~acc_q + 64'd1) : acc_q;
  end

  // State and datapath registers, cleared asynchronously by reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      count_q  <= '0;
      neg_q    <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      count_q  <= count_d;
      neg_q    <= neg_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
    end
  end

  // Next-state and datapath update; start is only honoured from IDLE.
  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    count_d  = count_q;
    neg_d    = neg_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          mcand_d  = {32'd0, mag_a};
          mplier_d = mag_b;
          neg_d    = bus.signed_mode & (bus.a[31] ^ bus.b[31]);
          acc_d    = '0;
          count_d  = '0;
          state_d  = BUSY;
`ifdef MULT_EARLY_TERM_EN
          if (mag_b == 32'd0) state_d = FIX;
`endif
        end
      end
      BUSY: begin
        if (mplier_q[0]) acc_d = acc_q + mcand_q;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        count_d  = count_q + 6'd1;
`ifdef MULT_EARLY_TERM_EN
        if (mplier_d == 32'd0) state_d = FIX;
`else
        if (count_q == 6'd31) state_d = FIX;
`endif
      end
      FIX: begin
        hi_d    = result[63:32];
        lo_d    = result[31:0];
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Status flags and the hazard-unit stall request.
  always_comb begin
    bus.busy  = (state_q != IDLE);
    bus.done  = (state_q == FIX);
    bus.stall = (bus.busy & (bus.mf_sel != 2'b00)) | (bus.busy & bus.start);
  end

  // HI/LO readback mux.
  always_comb begin
    case (bus.mf_sel)
      2'b01:   bus.mf_out = hi_q;
      2'b10:   bus.mf_out = lo_q;
      default: bus.mf_out = 32'd0;
    endcase
  end

endmodule

// File: tb/tb_mult_unit.sv
// Self-checking bench for mult_unit: directed corner cases plus random operands,
// compared against a plain-arithmetic product and latency model.
module tb_mult_unit;
  logic clk = 1'b0;
  logic reset;
  int   total = 0;
  int   bad = 0;
  logic [31:0] exp_hi, exp_lo;

  always #5 clk = ~clk;

  mult_if bus();

  mult_unit dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [63:0] ref_prod(input logic [31:0] a, input logic [31:0] b, input bit sgn);
    logic signed [63:0] sa, sb;
    if (sgn) begin
      sa = 64'($signed(a));
      sb = 64'($signed(b));
      return sa * sb;
    end
    return {32'd0, a} * {32'd0, b};
  endfunction

  // Edges from the start edge (counted as edge 1) to the edge that writes HI/LO.
  function automatic int exp_lat(input logic [31:0] b, input bit sgn);
`ifdef MULT_EARLY_TERM_EN
    logic [31:0] m;
    int h;
    m = (sgn && b[31]) ? -b : b;
    if (m == 0) return 2;
    h = 0;
    for (int i = 0; i < 32; i++) if (m[i]) h = i;
    return 3 + h;
`else
    return 34;
`endif
  endfunction

  task automatic read_hilo(input string tag, input logic [31:0] hi, input logic [31:0] lo);
    bus.mf_sel = 2'b01; #1;
    chk({tag, "_hi"}, bus.mf_out, hi);
    bus.mf_sel = 2'b10; #1;
    chk({tag, "_lo"}, bus.mf_out, lo);
  endtask

  // One multiply: optional start re-pulse in BUSY, start during FIX, mf_sel held from cycle 5.
  task automatic run_mult(input logic [31:0] a, input logic [31:0] b, input bit sgn,
                          input int repulse_at, input bit fix_start, input bit hold_sel);
    int lat;
    int n;
    logic [63:0] p;
    lat = exp_lat(b, sgn);
    p = ref_prod(a, b, sgn);
    bus.start = 1'b1; bus.a = a; bus.b = b; bus.signed_mode = sgn; bus.mf_sel = 2'b00;
    tick();
    n = 1;
    bus.start = 1'b0; bus.a = $urandom; bus.b = $urandom; bus.signed_mode = 1'($urandom_range(0, 1));
    chk("busy_after_start", bus.busy, 1);
    while (!bus.done && n < lat + 4) begin
      if (n == repulse_at) begin
        bus.start = 1'b1; bus.a = 32'd1; bus.b = 32'd1;
      end
      if (hold_sel && n == 5) begin
        bus.mf_sel = 2'b01; #1;
        chk("stall_mfhi_busy", bus.stall, 1);
      end
      tick();
      n++;
      bus.start = 1'b0;
    end
    chk("done_cycle", 64'(n), 64'(lat - 1));
    chk("done_seen", bus.done, 1);
    chk("busy_in_fix", bus.busy, 1);
    read_hilo("hold_old", exp_hi, exp_lo);
    chk("stall_in_fix", bus.stall, 1);
    if (fix_start) begin
      bus.start = 1'b1; bus.a = 32'd1; bus.b = 32'd1;
    end
    tick();
    bus.start = 1'b0;
    chk("done_after_fix", bus.done, 0);
    chk("busy_after_fix", bus.busy, 0);
    chk("stall_idle", bus.stall, 0);
    read_hilo("result", p[63:32], p[31:0]);
    bus.mf_sel = 2'b00;
    exp_hi = p[63:32];
    exp_lo = p[31:0];
  endtask

  initial begin
    logic [31:0] ra, rb;
    reset = 1'b1;
    bus.start = 1'b0; bus.signed_mode = 1'b0; bus.a = '0; bus.b = '0; bus.mf_sel = 2'b00;
    exp_hi = '0; exp_lo = '0;
    tick();
    tick();
    chk("rst_busy", bus.busy, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_stall", bus.stall, 0);
    read_hilo("rst", 32'd0, 32'd0);
    bus.mf_sel = 2'b00;
    reset = 1'b0;

    run_mult(32'd3, 32'd5, 1'b0, 0, 1'b0, 1'b0);
    run_mult(32'hFFFFFFFF, 32'd2, 1'b1, 0, 1'b0, 1'b0);
    run_mult(32'h80000000, 32'h80000000, 1'b1, 0, 1'b0, 1'b0);
    run_mult(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 0, 1'b0, 1'b0);
    run_mult(32'h80000000, 32'hFFFFFFFF, 1'b1, 0, 1'b0, 1'b0);
    run_mult(32'h12345678, 32'd0, 1'b1, 0, 1'b0, 1'b0);
    run_mult(32'h7FFFFFFF, 32'h80000000, 1'b1, 0, 1'b0, 1'b1);
    run_mult(32'd6, 32'd7, 1'b0, 12, 1'b0, 1'b0);
    run_mult(32'hFFFFFFF9, 32'd9, 1'b1, 0, 1'b1, 1'b0);

    // Reset in the middle of 7*9: abort, HI/LO cleared, no done.
    bus.start = 1'b1; bus.a = 32'd7; bus.b = 32'd9; bus.signed_mode = 1'b0;
    tick();
    bus.start = 1'b0;
    for (int i = 1; i < 10; i++) tick();
    #1 reset = 1'b1;
    #1;
    chk("midrst_busy", bus.busy, 0);
    chk("midrst_done", bus.done, 0);
    read_hilo("midrst", 32'd0, 32'd0);
    bus.mf_sel = 2'b00;
    tick();
    chk("midrst_done_later", bus.done, 0);
    reset = 1'b0;
    exp_hi = '0; exp_lo = '0;
    run_mult(32'd7, 32'd9, 1'b0, 0, 1'b0, 1'b0);

    for (int k = 0; k < 16; k++) begin
      ra = $urandom;
      rb = $urandom;
      case ($urandom_range(0, 5))
        0: ra = 32'h80000000;
        1: rb = 32'h80000000;
        2: rb = rb >> $urandom_range(0, 31);
        3: ra = 32'hFFFFFFFF;
        default: ;
      endcase
      run_mult(ra, rb, 1'($urandom_range(0, 1)), 0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Global time bound so the bench always terminates.
  initial begin
    #200000;
    $display("FAIL timeout total=%0d bad=%0d", total, bad);
    $fatal(1, "timeout");
  end

endmodule
